// File: rtl/mlaccel_sequencer.sv
// mlaccel_sequencer: fetches packed 32-bit instructions from 64-bit main memory
// into a small FIFO and streams them to mlaccel_compute over cmd_valid/cmd_ready.
// Optional feature: define MLACCEL_SEQ_PERF_EN to enable the saturating
// perf_stall counter; otherwise perf_stall is tied to zero.
module mlaccel_sequencer #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_valid,
  output logic        start_ready,
  input  logic [15:0] start_addr,
  input  logic [15:0] start_count,
  input  logic        abort,
  output logic        busy,
  output logic        done,
  output logic        mem_ren,
  input  logic        mem_gnt,
  output logic [15:0] mem_addr,
  input  logic [63:0] mem_rdata,
  output logic        cmd_valid,
  input  logic        cmd_ready,
  output logic [31:0] cmd_insn,
  output logic [31:0] perf_stall
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN} state_t;

  state_t        state_q;
  logic [15:0]   addr_q;
  logic [15:0]   req_left_q;
  logic [15:0]   issue_left_q;
  logic [15:0]   issue_left_d;
  logic [1:0]    halves_p0_q;
  logic [1:0]    halves_p1_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW-1:0] wr_ptr_nx;
  logic [PW-1:0] rd_ptr_q;
  logic [CW-1:0] occ_q;
  logic [CW-1:0] occ_d;
  logic          done_q;
  logic [31:0]   fifo_q [FIFO_DEPTH];

  logic          flush;
  logic          start_fire;
  logic          grant;
  logic          pop;
  logic [1:0]    grant_halves;
  logic [1:0]    n_infl;
  logic [CW+1:0] used;

  assign flush        = reset || abort;
  assign start_ready  = (state_q == S_IDLE) && !reset;
  assign start_fire   = start_valid && start_ready && !abort;
  assign cmd_valid    = (occ_q != '0);
  assign cmd_insn     = fifo_q[rd_ptr_q];
  assign pop          = cmd_valid && cmd_ready;
  assign grant        = mem_ren && mem_gnt;
  assign grant_halves = (req_left_q >= 16'd2) ? 2'd2 : 2'd1;
  assign n_infl       = {1'b0, |halves_p0_q} + {1'b0, |halves_p1_q};
  // Every outstanding read reserves two slots, even an odd tail that returns one.
  assign used         = {2'b00, occ_q} + {{(CW-1){1'b0}}, n_infl, 1'b0};
  // Credits only shrink on our own grant, so mem_ren cannot drop while ungranted.
  assign mem_ren      = (state_q == S_FETCH) && (req_left_q != 16'd0) &&
                        (used <= (CW+2)'(FIFO_DEPTH - 2));
  assign mem_addr     = addr_q;
  assign busy         = (state_q != S_IDLE) || (occ_q != '0) ||
                        (halves_p0_q != 2'd0) || (halves_p1_q != 2'd0);
  assign done         = done_q;
  assign occ_d        = occ_q + CW'(halves_p1_q) - CW'(pop);
  assign issue_left_d = issue_left_q - {15'd0, pop};
  assign wr_ptr_nx    = wr_ptr_q + PW'(1);

  // Instruction storage: low half first, high half only for full pairs.
  always_ff @(posedge clock) begin
    if (!flush && (halves_p1_q != 2'd0)) begin
      fifo_q[wr_ptr_q] <= mem_rdata[31:0];
      if (halves_p1_q == 2'd2) begin
        fifo_q[wr_ptr_nx] <= mem_rdata[63:32];
      end
    end
  end

  // Sequencer FSM, read-return tracking and FIFO pointers.
  always_ff @(posedge clock) begin
    if (flush) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      req_left_q   <= '0;
      issue_left_q <= '0;
      halves_p0_q  <= '0;
      halves_p1_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      occ_q        <= '0;
      done_q       <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      // grant -> p0 -> p1: p1 lines up with mem_rdata two cycles after grant
      halves_p0_q  <= grant ? grant_halves : 2'd0;
      halves_p1_q  <= halves_p0_q;
      // p1 -> FIFO push
      wr_ptr_q     <= wr_ptr_q + PW'(halves_p1_q);
      rd_ptr_q     <= rd_ptr_q + PW'(pop);
      occ_q        <= occ_d;
      issue_left_q <= issue_left_d;
      case (state_q)
        S_IDLE: begin
          if (start_fire) begin
            addr_q       <= start_addr;
            req_left_q   <= start_count;
            issue_left_q <= start_count;
            if (start_count == 16'd0) begin
              done_q <= 1'b1;
            end else begin
              state_q <= S_FETCH;
            end
          end
        end
        S_FETCH: begin
          if (grant) begin
            addr_q     <= addr_q + 16'd1;
            req_left_q <= req_left_q - {14'd0, grant_halves};
            if (req_left_q == {14'd0, grant_halves}) begin
              state_q <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if ((issue_left_d == 16'd0) && (halves_p0_q == 2'd0) &&
              (halves_p1_q == 2'd0)) begin
            state_q <= S_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef MLACCEL_SEQ_PERF_EN
  logic [31:0] perf_q;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

  // Stall counter: busy cycles without a command handshake; abort keeps the count.
  always_ff @(posedge clock) begin
    if (reset || start_fire) begin
      perf_q <= '0;
    end else if (busy && !pop) begin
      perf_q <= sat_inc(perf_q);
    end
  end

  assign perf_stall = perf_q;
`else
  assign perf_stall = '0;
`endif

endmodule

// File: tb/tb_mlaccel_sequencer.sv
// Directed bench for mlaccel_sequencer: vector table plus an abort sequence,
// with a small memory model and an instruction scoreboard.
module tb_mlaccel_sequencer;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic        start_valid;
  logic        start_ready;
  logic [15:0] start_addr;
  logic [15:0] start_count;
  logic        abort;
  logic        busy;
  logic        done;
  logic        mem_ren;
  logic        mem_gnt;
  logic [15:0] mem_addr;
  logic [63:0] mem_rdata;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [31:0] cmd_insn;
  logic [31:0] perf_stall;

  mlaccel_sequencer #(.FIFO_DEPTH(DEPTH)) dut (
    .clock(clock), .reset(reset),
    .start_valid(start_valid), .start_ready(start_ready),
    .start_addr(start_addr), .start_count(start_count),
    .abort(abort), .busy(busy), .done(done),
    .mem_ren(mem_ren), .mem_gnt(mem_gnt), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_insn(cmd_insn),
    .perf_stall(perf_stall)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [15:0] addr;
    logic [15:0] cnt;
    int gm;     // 0: grant always, 1: grant on odd cycles
    int rm;     // 0: ready always, 1: ready low cycles 1..30, 2: ready on even cycles
    int reads;  // expected memory reads
    int dn;     // expected done cycle (-1: not checked)
    int pk;     // expected peak occupancy (-1: not checked)
  } vec_t;

  vec_t vecs [8];

  int total, bad;
  int cyc, exp_n, k, nreads, req_rem, done_cnt, done_cyc, occ_m, peak;
  logic [15:0] exp_base, next_raddr, held_addr;
  logic ren_hold;
  logic m_v0, m_v1, p_v0, p_v1;
  logic [15:0] m_a0, m_a1;
  int p_h0, p_h1;
  logic s_busy, s_ren, s_sr, s_cv;

  function automatic logic [63:0] word(input logic [15:0] a);
    if (a == 16'h0010) return {32'h2222_2222, 32'h1111_1111};
    if (a == 16'h0011) return {32'h4444_4444, 32'h3333_3333};
    return {16'hB000, a, 16'hA000, a};
  endfunction

  function automatic logic [31:0] exp_insn(input logic [15:0] base, input int idx);
    logic [15:0] wa;
    logic [63:0] w;
    wa = base + 16'(idx / 2);
    w  = word(wa);
    return ((idx % 2) == 1) ? w[63:32] : w[31:0];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // One clock cycle: drive inputs, sample, score, advance to next edge + 1.
  task automatic step(input bit g, input bit r, input bit a, input bit sv,
                      input logic [15:0] sa, input logic [15:0] sc);
    bit gr, pp;
    int h;
    mem_gnt = g; cmd_ready = r; abort = a; start_valid = sv;
    start_addr = sa; start_count = sc;
    mem_rdata = m_v1 ? word(m_a1) : 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    s_busy = busy; s_ren = mem_ren; s_sr = start_ready; s_cv = cmd_valid;
    if (ren_hold) begin
      check("ren_hold", 64'(mem_ren), 64'd1);
      check("addr_hold", 64'(mem_addr), 64'(held_addr));
    end
    ren_hold  = mem_ren && !g && !a;
    held_addr = mem_addr;
    check("cmd_valid", 64'(cmd_valid), 64'(occ_m != 0));
    if (exp_n == 0) check("busy_zero", 64'(busy), 64'd0);
    gr = mem_ren && g;
    pp = cmd_valid && r;
    h = 0;
    if (gr && !a) begin
      nreads++;
      check("raddr", 64'(mem_addr), 64'(next_raddr));
      next_raddr = next_raddr + 16'd1;
      h = (req_rem >= 2) ? 2 : 1;
      req_rem -= h;
    end
    if (pp) begin
      if (k < exp_n) check("insn", 64'(cmd_insn), 64'(exp_insn(exp_base, k)));
      else begin
        total++; bad++;
        $display("FAIL extra_insn actual=%h required=none", cmd_insn);
      end
      k++;
    end
    if (done) begin done_cnt++; done_cyc = cyc; end
    // memory keeps returning data for every grant, abort or not
    m_v1 = m_v0; m_a1 = m_a0; m_v0 = gr; m_a0 = mem_addr;
    if (a) begin
      occ_m = 0; p_v0 = 1'b0; p_v1 = 1'b0;
    end else begin
      if (p_v1) occ_m += p_h1;
      if (pp) occ_m--;
      p_v1 = p_v0; p_h1 = p_h0; p_v0 = gr; p_h0 = h;
    end
    if (occ_m > peak) peak = occ_m;
    if (sv && start_ready && !a) begin
      exp_base = sa; exp_n = int'(sc); k = 0; nreads = 0;
      next_raddr = sa; req_rem = int'(sc); peak = 0; cyc = 0;
    end
    @(posedge clock); #1;
    cyc++;
  endtask

  task automatic run_body(input int gm, input int rm);
    bit g, r;
    for (int c = 1; c < 400 && done_cnt == 0; c++) begin
      g = (gm == 1) ? ((c % 2) == 1) : 1'b1;
      r = (rm == 1) ? (c > 30) : (rm == 2) ? ((c % 2) == 0) : 1'b1;
      step(g, r, 1'b0, 1'b0, 16'd0, 16'd0);
    end
    if (done_cnt == 0) begin
      total++; bad++;
      $display("FAIL done_timeout actual=none required=pulse");
    end
  endtask

  task automatic final_checks(input int n, input int reads, input int dn, input int pk);
    check("issued", 64'(k), 64'(n));
    check("reads", 64'(nreads), 64'(reads));
    if (dn >= 0) check("done_cycle", 64'(done_cyc), 64'(dn));
    if (pk >= 0) check("peak_occ", 64'(peak), 64'(pk));
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    check("done_once", 64'(done_cnt), 64'd1);
    check("busy_idle", 64'(s_busy), 64'd0);
    check("start_ready_idle", 64'(s_sr), 64'd1);
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0; exp_n = 1; k = 0; nreads = 0; req_rem = 0;
    done_cnt = 0; done_cyc = -1; occ_m = 0; peak = 0;
    exp_base = '0; next_raddr = '0; held_addr = '0; ren_hold = 1'b0;
    m_v0 = 1'b0; m_v1 = 1'b0; p_v0 = 1'b0; p_v1 = 1'b0;
    m_a0 = '0; m_a1 = '0; p_h0 = 0; p_h1 = 0;

    vecs[0] = '{16'h0010, 16'd4,  0, 0, 2,  8,  -1};
    vecs[1] = '{16'h0010, 16'd3,  0, 0, 2,  7,  -1};
    vecs[2] = '{16'h1234, 16'd0,  0, 0, 0,  1,  -1};
    vecs[3] = '{16'h0100, 16'd20, 0, 1, 10, -1, DEPTH};
    vecs[4] = '{16'hFFFF, 16'd4,  0, 0, 2,  8,  -1};
    vecs[5] = '{16'h0200, 16'd1,  0, 0, 1,  5,  -1};
    vecs[6] = '{16'h0300, 16'd7,  1, 2, 4,  -1, -1};
    vecs[7] = '{16'h0050, 16'd16, 0, 0, 8,  20, -1};

    reset = 1'b1; start_valid = 1'b0; start_addr = '0; start_count = '0;
    abort = 1'b0; mem_gnt = 1'b0; mem_rdata = '0; cmd_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_start_ready", 64'(start_ready), 64'd0);
    check("rst_mem_ren", 64'(mem_ren), 64'd0);
    check("rst_cmd_valid", 64'(cmd_valid), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_perf", 64'(perf_stall), 64'd0);
    reset = 1'b0;
    #1;
    check("post_rst_start_ready", 64'(start_ready), 64'd1);

    for (int i = 0; i < 8; i++) begin
      done_cnt = 0; done_cyc = -1;
      step(1'b1, 1'b1, 1'b0, 1'b1, vecs[i].addr, vecs[i].cnt);
      check("start_ready", 64'(s_sr), 64'd1);
      run_body(vecs[i].gm, vecs[i].rm);
      final_checks(int'(vecs[i].cnt), vecs[i].reads, vecs[i].dn, vecs[i].pk);
      if (i == 3) begin
`ifdef MLACCEL_SEQ_PERF_EN
        check("perf_ge30", 64'(perf_stall >= 32'd30), 64'd1);
`else
        check("perf_zero", 64'(perf_stall), 64'd0);
`endif
      end
    end

    // Abort the cycle after the first grant, then restart immediately.
    done_cnt = 0; done_cyc = -1;
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0400, 16'd8);
    step(1'b1, 1'b1, 1'b0, 1'b0, 16'd0, 16'd0);
    step(1'b1, 1'b1, 1'b1, 1'b0, 16'd0, 16'd0);
    step(1'b1, 1'b1, 1'b0, 1'b1, 16'h0010, 16'd4);
    check("abort_mem_ren", 64'(s_ren), 64'd0);
    check("abort_cmd_valid", 64'(s_cv), 64'd0);
    check("abort_busy", 64'(s_busy), 64'd0);
    check("abort_start_ready", 64'(s_sr), 64'd1);
    check("abort_no_done", 64'(done_cnt), 64'd0);
    run_body(0, 0);
    final_checks(4, 2, 8, -1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mlaccel_sequencer.md
# mlaccel_sequencer

Instruction fetch sequencer directly upstream of `mlaccel_compute`. It takes a start request (word address plus instruction count), fetches packed 32-bit instructions from the shared 64-bit main memory, and buffers them in a small FIFO. It then drives them into the compute block's `cmd_valid`/`cmd_ready`/`cmd_insn` port, so long programs run without host involvement per instruction. Memory access goes through its own request port; an external arbiter grants it against compute traffic.

## Interface
- `FIFO_DEPTH`, 8: instruction FIFO entries; power of two, minimum 4.
- `clock`  in  1  single clock domain, all logic on rising edge.
- `reset`  in  1  synchronous, active-high.
- `start_valid`  in  1  start request.
- `start_ready`  out  1  high only in IDLE and not in reset.
- `start_addr`  in  16  64-bit word address of first instruction pair.
- `start_count`  in  16  number of 32-bit instructions to issue.
- `abort`  in  1  cancel current program.
- `busy`  out  1  state != IDLE, or FIFO non-empty, or read in flight.
- `done`  out  1  one-cycle pulse at program completion.
- `mem_ren`  out  1  read request.
- `mem_gnt`  in  1  request accepted this cycle (qualifies `mem_ren`).
- `mem_addr`  out  16  word address.
- `mem_rdata`  in  64  read data, valid exactly 2 cycles after a granted request.
- `cmd_valid`  out  1  instruction available to compute.
- `cmd_ready`  in  1  compute accepts.
- `cmd_insn`  out  32  instruction.
- `perf_stall`  out  32  stall-cycle counter (see Configuration).

## Operation
- States: IDLE, FETCH, DRAIN.
- IDLE: on `start_valid && start_ready`, latch `addr=start_addr`, `req_left=start_count`, `issue_left=start_count`.
  - If `start_count==0`: stay IDLE, pulse `done` next cycle.
  - Otherwise go to FETCH.
- FETCH: assert `mem_ren` when `free >= 2`, where `free = FIFO_DEPTH - occupancy - 2*inflight`.
  - On grant: `addr+=1` (wraps 0xFFFF→0x0000), `req_left -= min(2, req_left)`, record in a 2-stage in-flight shift register the number of valid halves (1 or 2).
  - When `req_left` reaches 0: go to DRAIN.
- Return data: the low half `[31:0]` is pushed before the high half `[63:32]`. For an odd final count, the high half is discarded.
- The FIFO accepts two pushes per cycle and pops one per cycle. `cmd_insn` is the registered FIFO head. Each `cmd_valid && cmd_ready` decrements `issue_left`.
- DRAIN: no new requests. When `issue_left` reaches 0 with nothing in flight: pulse `done`, go to IDLE.
- Instructions are not decoded; opcodes pass unchanged.
- `abort` (any state):
  - Next cycle: state IDLE, FIFO empty, `cmd_valid=0`, `mem_ren=0`, in-flight markers cleared. Data returning afterwards is ignored.
  - No `done` pulse.
  - A `cmd_valid && cmd_ready` handshake in the abort cycle still counts as issued.
- Reset gives the same result as abort. Reset values: `start_ready=0` while in reset, then 1; `mem_ren=0`; `cmd_valid=0`; `done=0`; `busy=0`; `perf_stall=0`; `mem_addr`/`cmd_insn` don't-care.

## Timing
- Start handshake at cycle 0 → first `mem_ren` at cycle 1.
- Granted at cycle 1 → `mem_rdata` sampled at cycle 3 → `cmd_valid` high at cycle 4 with the low half.
- Back-to-back grants with `cmd_ready` held high: one instruction per cycle, no bubbles after the first.
- `mem_ren` may only deassert after a grant or on abort/reset. While ungranted, `mem_addr` stays stable.
- `cmd_valid` and `cmd_insn` hold stable until accepted.
- `done` pulses the cycle after the final handshake, together with the IDLE transition. `start_ready` rises in that same cycle.
- FIFO full: `mem_ren` is held low by the credit rule; it never overflows.
- Simultaneous push and pop at full or empty occupancy is legal.

## Configuration
- `MLACCEL_SEQ_PERF_EN`
  - Defined: `perf_stall` increments (saturating at 0xFFFFFFFF) in each cycle with `busy && !(cmd_valid && cmd_ready)`. It clears on reset and on accepted start; `abort` does not clear it.
  - Undefined: `perf_stall` is constant 0 and the counter logic is absent.

## Test plan
- Start `addr=0x0010`, `count=4`, memory words `0x0010={0x22222222,0x11111111}` and `0x0011={0x44444444,0x33333333}`, grant and ready always high → `cmd_insn` 0x11111111, 0x22222222, 0x33333333, 0x44444444 on cycles 4–7; `done` at cycle 8.
- `count=3` → exactly 3 instructions issued, high half of the second word dropped, two memory reads total.
- `count=0` → no `mem_ren`; `done` one cycle after start; `busy` stays 0.
- `count=20`, `cmd_ready` low for 30 cycles → occupancy peaks at `FIFO_DEPTH`, `mem_ren` stops, no instruction lost or duplicated once ready returns. With `MLACCEL_SEQ_PERF_EN`, `perf_stall` ≥ 30.
- `start_addr=0xFFFF`, `count=4` → reads issued at 0xFFFF then 0x0000.
- `abort` raised the cycle after a grant, `count=8` → `cmd_valid` low next cycle, late `mem_rdata` not pushed, no `done`, and a new start is accepted immediately and runs correctly.
